bit_fifo_reader: RTL and testbench

- Drain side of the 1-bit, 4-deep shift FIFO (pop/push/clear, output P).
- Pops bits one at a time and assembles them into a WORD_W-bit word.
- Presents each completed word on a valid/ready handshake to the consumer, e.g. the MicroEV20 instruction/data latch.
- Owns the FIFO's pop and clear inputs; the producer keeps push and I.

---
 rtl/ev_fifo_pkg.sv | 15 +
 rtl/bit_fifo_reader.sv | 108 ++++++++++
 tb/tb_bit_fifo_reader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ev_fifo_pkg.sv
// Shared definitions for the 1-bit shift FIFO drain side: FSM encoding and
// the FIFO depth both ends agree on.
package ev_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_CAPT  = 3'd2,
        ST_FULL  = 3'd3,
        ST_FLUSH = 3'd4
    } rd_state_e;

    localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/bit_fifo_reader.sv
// Drains a 1-bit shift FIFO one pop at a time, assembles WORD_W-bit words and
// hands them to the consumer on a valid/ready handshake.
module bit_fifo_reader
    import ev_fifo_pkg::*;
#(
    parameter int WORD_W    = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CNT_W    = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    input  logic              fifo_bit,
    output logic              fifo_pop,
    output logic              fifo_clear,
    input  logic              flush,
    output logic [WORD_W-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  bit_cnt
);

    rd_state_e         state_q;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              pop_q, clear_q, valid_q;

    always_comb begin
        shreg_d = shreg_q;
        if (MSB_FIRST) shreg_d = {shreg_q[WORD_W-2:0], fifo_bit};
        else           shreg_d = {fifo_bit, shreg_q[WORD_W-1:1]};
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            pop_q   <= 1'b0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pop_q   <= 1'b0;
            clear_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        state_q <= ST_FLUSH;
                        clear_q <= 1'b1;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end else if (!fifo_empty) begin
                        state_q <= ST_POP;
                        pop_q   <= 1'b1;
                    end
                end
                ST_POP: state_q <= ST_CAPT;
                ST_CAPT: begin
                    if (flush) begin
                        state_q <= ST_FLUSH;
                        clear_q <= 1'b1;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end else begin
                        shreg_q <= shreg_d;
                        cnt_q   <= cnt_inc;
                        if (cnt_inc == CNT_W'(WORD_W)) begin
                            state_q <= ST_FULL;
                            valid_q <= 1'b1;
                        // Occupancy here already reflects the pop just taken, so
                        // chaining straight into the next pop is safe and keeps 2 cycles/bit.
                        end else if (!fifo_empty) begin
                            state_q <= ST_POP;
                            pop_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    if (flush) begin
                        state_q <= ST_FLUSH;
                        clear_q <= 1'b1;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end else if (word_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        shreg_q <= '0;
                    end
                end
                ST_FLUSH: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_pop   = pop_q;
    assign fifo_clear = clear_q;
    assign word_valid = valid_q;
    assign word       = shreg_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_bit_fifo_reader.sv
// Bench for bit_fifo_reader: a queue-based FIFO model feeds an MSB-first and
// an LSB-first instance in lockstep; words are checked against pushed bits.
module tb_bit_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_bit = 1'b0;
    logic       flush = 1'b0;
    logic       word_ready = 1'b1;
    logic       push = 1'b0;
    logic       push_bit = 1'b0;
    logic       pop_m, clr_m, val_m, pop_l, clr_l, val_l;
    logic [3:0] word_m, word_l;
    logic [2:0] cnt_m, cnt_l;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int clr_n = 0;
    int viol = 0;
    int div = 0;
    bit q[$];
    int pop_cyc[$];

    always #5 clk = ~clk;

    bit_fifo_reader #(.WORD_W(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_bit(fifo_bit),
        .fifo_pop(pop_m), .fifo_clear(clr_m), .flush(flush), .word(word_m),
        .word_valid(val_m), .word_ready(word_ready), .bit_cnt(cnt_m)
    );

    bit_fifo_reader #(.WORD_W(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_bit(fifo_bit),
        .fifo_pop(pop_l), .fifo_clear(clr_l), .flush(flush), .word(word_l),
        .word_valid(val_l), .word_ready(word_ready), .bit_cnt(cnt_l)
    );

    // 4-deep FIFO: a pop loads the head into P, which then holds the popped bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            fifo_bit   <= 1'b0;
            fifo_empty <= 1'b1;
        end else begin
            if (clr_m) q.delete();
            else begin
                if (pop_m && q.size() > 0) begin
                    fifo_bit <= q[0];
                    void'(q.pop_front());
                end
                if (push && q.size() < 4) q.push_back(push_bit);
            end
            fifo_empty <= (q.size() == 0);
        end
    end

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (pop_m && fifo_empty) viol++;
            if (pop_m && clr_m) viol++;
            if (pop_m) pop_cyc.push_back(cyc);
            if (clr_m) clr_n++;
            if ({pop_m, clr_m, val_m, cnt_m} !== {pop_l, clr_l, val_l, cnt_l}) div++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_word(input bit msb, input logic [3:0] b);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (msb) r[3-i] = b[i];
            else     r[i]   = b[i];
        end
        return r;
    endfunction

    // b[0] is pushed first.
    task automatic push_bits(input logic [3:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push     = 1'b1;
            push_bit = b[i];
        end
        @(negedge clk);
        push = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (val_m !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_valid_seen"}, 32'(k < 100), 32'd1);
    endtask

    task automatic check_word(input string tag, input logic [3:0] b);
        chk({tag, "_msb"}, word_m, exp_word(1'b1, b));
        chk({tag, "_lsb"}, word_l, exp_word(1'b0, b));
    endtask

    initial begin
        logic [3:0] b, b2, w0;
        int k, stable, clr0;

        repeat (3) @(negedge clk);
        chk("rst_word", word_m, 4'd0);
        chk("rst_valid", val_m, 1'b0);
        chk("rst_pop", pop_m, 1'b0);
        chk("rst_clear", clr_m, 1'b0);
        chk("rst_cnt", cnt_m, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_pop", 32'(pop_cyc.size()), 32'd0);

        // Basic word 1,0,1,1
        pop_cyc.delete();
        push_bits(4'b1101, 4);
        wait_valid("basic");
        check_word("basic", 4'b1101);
        chk("basic_pops", 32'(pop_cyc.size()), 32'd4);
        for (int i = 1; i < pop_cyc.size(); i++)
            chk("basic_pop_gap", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd2);
        @(negedge clk);
        chk("basic_accept", val_m, 1'b0);

        // Starve after 2 bits
        b = 4'($urandom);
        push_bits(b, 2);
        repeat (20) @(negedge clk);
        chk("starve_cnt", cnt_m, 3'd2);
        chk("starve_valid", val_m, 1'b0);
        pop_cyc.delete();
        repeat (10) @(negedge clk);
        chk("starve_no_pop", 32'(pop_cyc.size()), 32'd0);
        push_bits({2'b00, b[3:2]}, 2);
        wait_valid("starve");
        check_word("starve", b);
        @(negedge clk);

        // Back-pressure in FULL while the FIFO refills
        word_ready = 1'b0;
        b = 4'($urandom);
        b2 = 4'($urandom);
        push_bits(b, 4);
        wait_valid("bp");
        w0 = word_m;
        pop_cyc.delete();
        push_bits(b2, 4);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (val_m !== 1'b1 || word_m !== w0) stable = 0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_no_pop", 32'(pop_cyc.size()), 32'd0);
        check_word("bp", b);
        word_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_fall", val_m, 1'b0);
        wait_valid("bp_next");
        check_word("bp_next", b2);
        @(negedge clk);

        // Flush with 3 bits collected
        b = 4'($urandom);
        push_bits(b, 3);
        k = 0;
        while (cnt_m !== 3'd3 && k < 50) begin @(negedge clk); k++; end
        chk("flush_cnt3_seen", 32'(k < 50), 32'd1);
        repeat (3) @(negedge clk);
        clr0 = clr_n;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("flush_clear_pulses", 32'(clr_n - clr0), 32'd1);
        chk("flush_cnt", cnt_m, 3'd0);
        chk("flush_valid", val_m, 1'b0);
        b2 = 4'($urandom);
        push_bits(b2, 4);
        wait_valid("flush_next");
        check_word("flush_next", b2);
        @(negedge clk);

        // Flush beats word_ready=0 in FULL: word dropped
        word_ready = 1'b0;
        push_bits(4'($urandom), 4);
        wait_valid("fullflush");
        clr0 = clr_n;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("fullflush_valid", val_m, 1'b0);
        chk("fullflush_cnt", cnt_m, 3'd0);
        chk("fullflush_clear", 32'(clr_n - clr0), 32'd1);
        word_ready = 1'b1;

        // Asynchronous reset in CAPT with a partial word
        push_bits(4'($urandom), 3);
        k = 0;
        while (!(cnt_m === 3'd2 && pop_m === 1'b1) && k < 50) begin @(negedge clk); k++; end
        chk("rstmid_seen", 32'(k < 50), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_cnt", cnt_m, 3'd0);
        chk("rstmid_word", word_m, 4'd0);
        chk("rstmid_valid", val_m, 1'b0);
        chk("rstmid_pop", pop_m, 1'b0);
        chk("rstmid_clear", clr_m, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b = 4'($urandom);
        push_bits(b, 4);
        wait_valid("rstmid_next");
        check_word("rstmid_next", b);
        @(negedge clk);

        // Random words with random acceptance delay
        for (int n = 0; n < 6; n++) begin
            word_ready = 1'b0;
            b = 4'($urandom);
            push_bits(b, 4);
            wait_valid("rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check_word("rand", b);
            word_ready = 1'b1;
            @(negedge clk);
            chk("rand_accept", val_m, 1'b0);
        end

        chk("pop_invariants", 32'(viol), 32'd0);
        chk("instances_lockstep", 32'(div), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
